// File: rtl/spi_frame_rx.sv
// SPI frame receiver: synchronizes an external SPI master into clk, assembles
// a FRAME_W-bit frame, hands it off with a valid/ready pair and echoes the previous frame on sdo.
module spi_frame_rx #(
    parameter int WORD_W  = 16,
    parameter int N_WORDS = 2,
    parameter int CPOL    = 0,
    parameter int CPHA    = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sck,
    input  logic                        sdi,
    input  logic                        load,
    output logic                        sdo,
    output logic [WORD_W*N_WORDS-1:0]   frame,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic                        overrun,
    output logic                        short_frame
);
    localparam int FRAME_W = WORD_W * N_WORDS;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);
    localparam logic SCK_IDLE    = (CPOL != 0);
    localparam logic SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
    localparam logic SKIP_FIRST  = (CPHA != 0);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           sck_q;    // [0] meta, [1] sync, [2] previous sync
    logic [1:0]           sdi_q;
    logic [2:0]           load_q;
    logic [1:0]           ok_q;     // synchronizer pipeline has refilled since reset
    logic                 armed_q, armed_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic                 first_q, first_d;
    logic                 cap_q, cap_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 fv_q, fv_d;
    logic                 ovr_q, ovr_d;
    logic                 short_q, short_d;

    logic sck_s, sdi_s, load_s, load_rise;
    logic rise, fall, sample_edge, launch_edge, last_edge;

    assign sck_s       = sck_q[1];
    assign sdi_s       = sdi_q[1];
    assign load_s      = load_q[1];
    assign load_rise   = load_q[1] & ~load_q[2];
    assign rise        = sck_q[1] & ~sck_q[2];
    assign fall        = ~sck_q[1] & sck_q[2];
    assign sample_edge = SAMPLE_RISE ? rise : fall;
    assign launch_edge = SAMPLE_RISE ? fall : rise;
    assign last_edge   = sample_edge && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        first_d = first_q;
        cap_d   = 1'b0;
        frame_d = frame_q;
        fv_d    = fv_q;
        ovr_d   = ovr_q;
        short_d = 1'b0;

        // A load level seen high straight out of reset must first drop before it can open a frame.
        if (ok_q[1] && !load_s)
            armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (load_rise && armed_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = frame_q;
                    first_d = 1'b1;
                end
            end
            SHIFT: begin
                if (sample_edge) begin
                    rx_d  = {rx_q[FRAME_W-2:0], sdi_s};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (last_edge) begin
                    cap_d   = 1'b1;
                    state_d = load_s ? DONE : IDLE;
                end else if (!load_s) begin
                    short_d = (cnt_q != '0);
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!load_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && launch_edge) begin
            first_d = 1'b0;
            if (!(SKIP_FIRST && first_q))
                tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end

        if (fv_q && frame_ready)
            fv_d = 1'b0;
        // A completed frame may replace the held one only if that one is gone or leaving now.
        if (cap_q) begin
            if (!fv_q || frame_ready) begin
                frame_d = rx_q;
                fv_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sck_q   <= {3{SCK_IDLE}};
            sdi_q   <= '0;
            load_q  <= '0;
            ok_q    <= '0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            first_q <= 1'b0;
            cap_q   <= 1'b0;
            frame_q <= '0;
            fv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sck_q   <= {sck_q[1:0], sck};
            sdi_q   <= {sdi_q[0], sdi};
            load_q  <= {load_q[1:0], load};
            ok_q    <= {ok_q[0], 1'b1};
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            first_q <= first_d;
            cap_q   <= cap_d;
            frame_q <= frame_d;
            fv_q    <= fv_d;
            ovr_q   <= ovr_d;
            short_q <= short_d;
        end
    end

    assign sdo         = (state_q != IDLE) && tx_q[FRAME_W-1];
    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign overrun     = ovr_q;
    assign short_frame = short_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a mode-0 instance with default widths and a
// mode-3 instance with 8-bit words, driven by a behavioural SPI master.
module tb_spi_frame_rx;
    localparam int H = 8;   // sck half period in clk cycles

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sdi = 1'b0;
    logic sck0 = 1'b0, load0 = 1'b0, ready0 = 1'b0;
    logic sck1 = 1'b1, load1 = 1'b0, ready1 = 1'b0;
    logic sdo0, fv0, ovr0, short0;
    logic sdo1, fv1, ovr1, short1;
    logic [31:0] frame0, frame1;

    int n_pass = 0;
    int n_total = 0;
    int short_cnt = 0;

    always #5 clk = ~clk;

    spi_frame_rx dut0 (
        .clk(clk), .reset_n(reset_n), .sck(sck0), .sdi(sdi), .load(load0),
        .sdo(sdo0), .frame(frame0), .frame_valid(fv0), .frame_ready(ready0),
        .overrun(ovr0), .short_frame(short0)
    );

    spi_frame_rx #(.WORD_W(8), .N_WORDS(4), .CPOL(1), .CPHA(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .sck(sck1), .sdi(sdi), .load(load1),
        .sdo(sdo1), .frame(frame1), .frame_valid(fv1), .frame_ready(ready1),
        .overrun(ovr1), .short_frame(short1)
    );

    always @(negedge clk)
        if (short0 === 1'b1) short_cnt <= short_cnt + 1;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] data;
        int          nbits;
        bit          drop_last;
        bit          chk_sdo;
        logic [31:0] exp_sdo;
        bit          ack;
        logic [31:0] exp_frame;
        bit          exp_fv;
        bit          exp_ovr;
        int          exp_short;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sck(input bit which, input logic v);
        if (which) sck1 = v; else sck0 = v;
    endtask

    task automatic set_load(input bit which, input logic v);
        if (which) load1 = v; else load0 = v;
    endtask

    // which=0: mode 0 master for dut0, which=1: mode 3 master for dut1.
    task automatic spi_send(input logic [31:0] d, input int n, input bit which,
                            input bit drop_last, input bit keep_load,
                            output logic [31:0] sdo_got);
        logic cpol;
        cpol = which;
        sdo_got = '0;
        @(negedge clk);
        set_load(which, 1'b1);
        wait_clk(H);
        for (int i = 0; i < n; i++) begin
            if (!which) begin
                sdi = d[31-i];
                wait_clk(H);
                sdo_got[31-i] = sdo0;
                set_sck(which, ~cpol);
                if (drop_last && i == n - 1) set_load(which, 1'b0);
                wait_clk(H);
                set_sck(which, cpol);
            end else begin
                set_sck(which, ~cpol);
                sdi = d[31-i];
                wait_clk(H);
                set_sck(which, cpol);
                if (drop_last && i == n - 1) set_load(which, 1'b0);
                wait_clk(H);
            end
        end
        wait_clk(H);
        if (!keep_load) set_load(which, 1'b0);
        wait_clk(2 * H);
    endtask

    initial begin
        vec_t vt[7];
        logic [31:0] got;
        int s0;

        vt[0] = '{32'hA5A53C3C, 32, 0, 1, 32'h00000000, 1, 32'hA5A53C3C, 1, 0, 0};
        vt[1] = '{32'h12345678, 32, 0, 1, 32'hA5A53C3C, 1, 32'h12345678, 1, 0, 0};
        vt[2] = '{32'h11112222, 32, 0, 1, 32'h12345678, 0, 32'h11112222, 1, 0, 0};
        vt[3] = '{32'h33334444, 32, 0, 1, 32'h11112222, 1, 32'h11112222, 1, 1, 0};
        vt[4] = '{32'hABCDE000, 20, 0, 0, 32'h00000000, 0, 32'h11112222, 0, 1, 1};
        vt[5] = '{32'hCAFEF00D, 32, 0, 1, 32'h11112222, 1, 32'hCAFEF00D, 1, 1, 0};
        vt[6] = '{32'h600DBEEF, 32, 1, 1, 32'hCAFEF00D, 0, 32'h600DBEEF, 1, 1, 0};

        wait_clk(4);
        check("reset frame", frame0, 32'h0);
        check("reset frame_valid", {31'b0, fv0}, 32'h0);
        check("reset overrun", {31'b0, ovr0}, 32'h0);
        check("reset short_frame", {31'b0, short0}, 32'h0);
        check("reset sdo", {31'b0, sdo0}, 32'h0);
        check("reset frame dut1", frame1, 32'h0);
        reset_n = 1'b1;
        wait_clk(6);

        for (int v = 0; v < 7; v++) begin
            s0 = short_cnt;
            spi_send(vt[v].data, vt[v].nbits, 1'b0, vt[v].drop_last, 1'b0, got);
            if (vt[v].chk_sdo) check($sformatf("v%0d sdo echo", v), got, vt[v].exp_sdo);
            check($sformatf("v%0d frame", v), frame0, vt[v].exp_frame);
            check($sformatf("v%0d frame_valid", v), {31'b0, fv0}, {31'b0, vt[v].exp_fv});
            check($sformatf("v%0d overrun", v), {31'b0, ovr0}, {31'b0, vt[v].exp_ovr});
            check($sformatf("v%0d short pulses", v), short_cnt - s0, vt[v].exp_short);
            if (vt[v].ack) begin
                wait_clk(20);
                check($sformatf("v%0d valid held", v), {31'b0, fv0}, 32'h1);
                ready0 = 1'b1;
                @(negedge clk);
                ready0 = 1'b0;
                check($sformatf("v%0d valid cleared", v), {31'b0, fv0}, 32'h0);
                check($sformatf("v%0d frame kept", v), frame0, vt[v].exp_frame);
            end
        end

        // Reset in the middle of a frame with load still asserted.
        s0 = short_cnt;
        spi_send(32'hF0F00000, 10, 1'b0, 1'b0, 1'b1, got);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid reset frame", frame0, 32'h0);
        check("mid reset frame_valid", {31'b0, fv0}, 32'h0);
        check("mid reset overrun", {31'b0, ovr0}, 32'h0);
        check("mid reset sdo", {31'b0, sdo0}, 32'h0);
        wait_clk(4);
        spi_send(32'h55AA55AA, 32, 1'b0, 1'b0, 1'b0, got);
        check("held load no frame", frame0, 32'h0);
        check("held load no valid", {31'b0, fv0}, 32'h0);
        check("reset no short", short_cnt - s0, 32'h0);
        spi_send(32'h0F0F1234, 32, 1'b0, 1'b0, 1'b0, got);
        check("post reset frame", frame0, 32'h0F0F1234);
        check("post reset valid", {31'b0, fv0}, 32'h1);

        // Mode 3 instance with 8-bit words.
        spi_send(32'hDEADBEEF, 32, 1'b1, 1'b0, 1'b0, got);
        check("mode3 frame", frame1, 32'hDEADBEEF);
        check("mode3 valid", {31'b0, fv1}, 32'h1);
        check("mode3 overrun", {31'b0, ovr1}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 Parameter WORD_W, default 16, bits per word.
REQ-002 Parameter N_WORDS, default 2, words per frame; FRAME_W = WORD_W*N_WORDS.
REQ-003 Parameter CPOL, default 0, sck idle level.
REQ-004 Parameter CPHA, default 0; 0 = sample on first sck edge, 1 = sample on second sck edge.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  system clock; all state updates on posedge clk.
REQ-007 reset_n  input  1  synchronous active-low reset.
REQ-008 sck  input  1  SPI clock, asynchronous to clk.
REQ-009 sdi  input  1  serial data in, MSB of word 0 first.
REQ-010 load  input  1  active-high frame enable, asynchronous.
REQ-011 sdo  output  1  serial echo of the previously captured frame.
REQ-012 frame  output  FRAME_W  last complete frame; word 0 in [FRAME_W-1 -: WORD_W].
REQ-013 frame_valid  output  1  frame holds unconsumed data.
REQ-014 frame_ready  input  1  consumer accepts frame when high with frame_valid.
REQ-015 overrun  output  1  sticky flag: a frame completed while frame_valid was high and not accepted.
REQ-016 short_frame  output  1  one-clk pulse when load falls mid-frame.

Function
REQ-017 sck, sdi and load SHALL each pass through a 2-flop synchronizer; sck edges are detected on the synchronized signal only.
REQ-018 Sample edge SHALL be rising sck when CPOL==CPHA, falling otherwise; launch edge is the opposite edge.
REQ-019 Operating constraint: clk >= 8x sck frequency; no behaviour is required outside this constraint.
REQ-020 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-021 IDLE to SHIFT on synchronized load rising; bit counter cleared; receive shift register cleared; tx register loaded with current frame.
REQ-022 In SHIFT, each sample edge SHALL shift sdi into the receive register LSB and increment the bit counter (width clog2(FRAME_W+1)).
REQ-023 On the sample edge that makes count == FRAME_W: the receive register is transferred to frame on the next clk, and the FSM enters DONE.
REQ-024 frame_valid SHALL rise on the same clk that frame updates, which is 1 clk after the final sample-edge detect.
REQ-025 frame_valid SHALL clear on the clk after the first clk with frame_valid && frame_ready.
REQ-026 If a frame completes while frame_valid=1 and frame_ready=0, the new frame is dropped, frame is unchanged, and overrun is set.
REQ-027 If a capture coincides with a handshake on the same clk, the new frame loads, frame_valid stays 1, and overrun is not set.
REQ-028 In DONE, further sample edges SHALL be ignored; load falling returns to IDLE.
REQ-029 In SHIFT, load falling with 0 < count < FRAME_W SHALL pulse short_frame for 1 clk, discard partial data, and return to IDLE; with count == 0, return to IDLE silently.
REQ-030 sdo SHALL be the tx register MSB while in SHIFT or DONE, and 0 in IDLE.
REQ-031 tx register shifts left, filling with 0, on each launch edge; when CPHA=1 the first launch edge of a frame does not shift.
REQ-032 Simultaneous load fall and final sample edge on the same clk: the frame completes (REQ-023) and the FSM goes to IDLE; no short_frame.

Reset
REQ-033 While reset_n=0 at posedge clk, all registers SHALL be set as follows: FSM=IDLE, count=0, frame=0, frame_valid=0, overrun=0, short_frame=0, sdo=0, tx=0, synchronizers = {CPOL, 0, 0}.
REQ-034 A reset asserted mid-frame SHALL abandon the frame with no short_frame pulse; a load still high after reset SHALL NOT start a frame until it falls and rises again.

Verification
REQ-035 Defaults, frame_ready=0, send 0xA5A53C3C -> frame=0xA5A53C3C and frame_valid=1, held until frame_ready=1, then cleared 1 clk after.
REQ-036 Second frame 0x12345678 after the first was accepted -> sdo bits over 32 sample edges equal 0xA5A53C3C MSB-first; frame=0x12345678.
REQ-037 Send 0x1111_2222 then 0x3333_4444 with frame_ready=0 throughout -> frame=0x11112222 and overrun=1 (sticky).
REQ-038 load drops after 20 bits -> single 1-clk short_frame pulse, frame and frame_valid unchanged, next full frame captured correctly.
REQ-039 CPOL=1, CPHA=1, WORD_W=8, N_WORDS=4, send 0xDEADBEEF -> frame=0xDEADBEEF.
REQ-040 reset_n=0 for 1 clk after 10 bits with load held high -> all outputs 0; frame starts only after load falls and rises again.
